// File: rtl/lcd_frame_display.sv
// ----------------------------------------------------------------------------
// lcd_frame_display
// Captures one greyscale camera frame into an inferred dual-port RAM and
// drives programmable RGB565 LCD timing. The stored image is shown in a
// window of the active area using a selectable pixel mode. Everything runs
// in the PixelClk domain.
//
// Ports:
//   PixelClk              sole clock
//   reset                 synchronous, active-high reset (RAM contents kept)
//   pixdata [PIX_W]       camera pixel
//   hsync                 camera line-valid, one pixel written per high cycle
//   vsync                 camera frame sync, low while a frame is in progress
//   freeze                hold the stored image once the current frame ends
//   mode [2]              0 grey, 1 threshold, 2 inverted grey, 3 see below
//   threshold [PIX_W]     compare value for threshold mode
//   LCD_DE/HSYNC/VSYNC    LCD timing (syncs active low)
//   LCD_R/G/B [5/6/5]     RGB565 pixel
//   frame_done            one-cycle pulse after the last buffer word is written
//   overflow              sticky, pixels arrived after the buffer filled
//
// Optional build macro LCD_TEST_PATTERN_EN: mode 3 shows eight vertical
// colour bars over the whole active area. Without it, mode 3 equals mode 0.
//
// Capture states:
//   state       | meaning
//   WAIT_HIGH   | after reset, wait for the camera frame sync to go high
//   WAIT_LOW    | wait for the next frame start (held here while frozen)
//   CAPTURE     | writing pixels, address advances per hsync cycle
//   FULL        | buffer complete, further pixels flag overflow
// ----------------------------------------------------------------------------
module lcd_frame_display #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 180,
    parameter int IMG_X = 80,
    parameter int IMG_Y = 150,
    parameter int H_ACT = 800,
    parameter int H_BP  = 182,
    parameter int H_FP  = 210,
    parameter int H_PW  = 1,
    parameter int V_ACT = 480,
    parameter int V_BP  = 6,
    parameter int V_FP  = 45,
    parameter int V_PW  = 5
) (
    input  logic             PixelClk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pixdata,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             freeze,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] threshold,
    output logic             LCD_DE,
    output logic             LCD_HSYNC,
    output logic             LCD_VSYNC,
    output logic [4:0]       LCD_R,
    output logic [5:0]       LCD_G,
    output logic [4:0]       LCD_B,
    output logic             frame_done,
    output logic             overflow
);

    localparam int H_TOT = H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_BP + V_ACT + V_FP;
    localparam int DEPTH = IMG_W * IMG_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    typedef enum logic [1:0] {S_WAIT_HIGH, S_WAIT_LOW, S_CAPTURE, S_FULL} cap_state_t;

    logic [HW-1:0]    r_h;
    logic [VW-1:0]    r_v;
    logic [HW-1:0]    w_ax;
    logic [VW-1:0]    w_ay;
    logic             w_de, w_hs, w_vs, w_win, w_we;
    logic             r_de_d, r_hs_d, r_vs_d, r_win_d;
    logic [1:0]       r_mode_d;
    logic [PIX_W-1:0] r_thr_d;
    logic [AW-1:0]    r_raddr, r_waddr;
    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PIX_W-1:0] r_rdata;
    cap_state_t       r_state;
    logic             r_frame_done, r_overflow;
    logic [5:0]       w_p;
    logic [4:0]       w_r, w_b;
    logic [5:0]       w_g;

    // ---------------- LCD timing ----------------
    always_ff @(posedge PixelClk) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == HW'(H_TOT - 1)) begin
            r_h <= '0;
            r_v <= (r_v == VW'(V_TOT - 1)) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_hs  = (r_h >= HW'(H_PW));
    assign w_vs  = (r_v >= VW'(V_PW));
    assign w_de  = (r_h >= HW'(H_BP)) && (r_h < HW'(H_BP + H_ACT)) &&
                   (r_v >= VW'(V_BP)) && (r_v < VW'(V_BP + V_ACT));
    // Only meaningful while w_de is high.
    assign w_ax  = r_h - HW'(H_BP);
    assign w_ay  = r_v - VW'(V_BP);
    assign w_win = w_de && (w_ax >= HW'(IMG_X)) && (w_ax < HW'(IMG_X + IMG_W)) &&
                   (w_ay >= VW'(IMG_Y)) && (w_ay < VW'(IMG_Y + IMG_H));

    // Everything below the RAM read is delayed one cycle so timing, window
    // flag, mode and threshold line up with the registered read data.
    always_ff @(posedge PixelClk) begin
        if (reset) begin
            r_de_d   <= 1'b0;
            r_hs_d   <= 1'b1;
            r_vs_d   <= 1'b1;
            r_win_d  <= 1'b0;
            r_mode_d <= 2'd0;
            r_thr_d  <= '0;
            r_raddr  <= '0;
        end else begin
            r_de_d   <= w_de;
            r_hs_d   <= w_hs;
            r_vs_d   <= w_vs;
            r_win_d  <= w_win;
            r_mode_d <= mode;
            r_thr_d  <= threshold;
            // Raster-order walk of the buffer; the window is scanned in the
            // same order the camera wrote it, so no address multiply is needed.
            if (w_win)
                r_raddr <= r_raddr + 1'b1;
            else if (r_v == '0)
                r_raddr <= '0;
        end
    end

    // ---------------- frame buffer ----------------
    assign w_we = !reset && (r_state == S_CAPTURE) && !vsync && hsync;

    // No reset: the image survives a reset. Read-before-write gives old data
    // on an address collision.
    always_ff @(posedge PixelClk) begin
        if (w_we)
            r_mem[r_waddr] <= pixdata;
        r_rdata <= r_mem[r_raddr];
    end

    // ---------------- capture FSM ----------------
    always_ff @(posedge PixelClk) begin
        if (reset) begin
            r_state      <= S_WAIT_HIGH;
            r_waddr      <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_WAIT_HIGH: if (vsync) r_state <= S_WAIT_LOW;
                S_WAIT_LOW: begin
                    if (!freeze && !vsync) begin
                        r_state <= S_CAPTURE;
                        r_waddr <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (vsync) begin
                        r_state <= S_WAIT_LOW;
                    end else if (hsync) begin
                        if (r_waddr == AW'(DEPTH - 1)) begin
                            r_state      <= S_FULL;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_waddr <= r_waddr + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (vsync)
                        r_state <= S_WAIT_LOW;
                    else if (hsync)
                        r_overflow <= 1'b1;
                end
                default: r_state <= S_WAIT_HIGH;
            endcase
        end
    end

`ifdef LCD_TEST_PATTERN_EN
    localparam int BAR_W = H_ACT / 8;
    localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [BCW-1:0] r_bcnt;
    logic [2:0]     r_bidx, r_bar_d;

    // Bar index tracked with a counter instead of dividing the x position.
    always_ff @(posedge PixelClk) begin
        if (reset) begin
            r_bcnt  <= '0;
            r_bidx  <= '0;
            r_bar_d <= '0;
        end else begin
            r_bar_d <= r_bidx;
            if (!w_de) begin
                r_bcnt <= '0;
                r_bidx <= '0;
            end else if (r_bcnt == BCW'(BAR_W - 1)) begin
                r_bcnt <= '0;
                r_bidx <= r_bidx + 1'b1;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end
`endif

    // ---------------- pixel mapping ----------------
    always_comb begin
        w_p = r_rdata[PIX_W-1 -: 6];
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (r_win_d) begin
            case (r_mode_d)
                2'd1: begin
                    if (r_rdata > r_thr_d) begin
                        w_r = '1;
                        w_g = '1;
                        w_b = '1;
                    end
                end
                2'd2: begin
                    w_r = ~w_p[5:1];
                    w_g = ~w_p;
                    w_b = ~w_p[5:1];
                end
                default: begin
                    w_r = w_p[5:1];
                    w_g = w_p;
                    w_b = w_p[5:1];
                end
            endcase
        end
`ifdef LCD_TEST_PATTERN_EN
        // Bar order white..black maps to R=!idx[1], G=!idx[2], B=!idx[0].
        if (r_mode_d == 2'd3) begin
            w_r = (r_de_d && !r_bar_d[1]) ? '1 : '0;
            w_g = (r_de_d && !r_bar_d[2]) ? '1 : '0;
            w_b = (r_de_d && !r_bar_d[0]) ? '1 : '0;
        end
`endif
    end

    assign LCD_DE     = r_de_d;
    assign LCD_HSYNC  = r_hs_d;
    assign LCD_VSYNC  = r_vs_d;
    assign LCD_R      = w_r;
    assign LCD_G      = w_g;
    assign LCD_B      = w_b;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule
